// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with credit-based flow control and flush sequencing for a shared FIFO.
// Latency: accept at edge N drives fifo_wr_en/fifo_data in cycle N+1. Backpressure: req_ready is all zero when out of credits or not in RUN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data,
    input  logic                      fifo_pop,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic [CW-1:0]             credits,
    output logic [GW-1:0]             last_grant,
    output logic                      err_underflow
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [GW-1:0] LAST_C = GW'(NUM_REQ - 1);

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant_idx;
    logic            found;
    logic            accept;
    logic            eligible;
    int              idx;

    assign eligible   = (state == RUN) && (credits != '0);
    assign accept     = |(req_valid & req_ready);
    assign flush_done = (state == DONE);

    // Scan upward from rr_ptr with wraparound; first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (eligible) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                idx = (int'(rr_ptr) + off) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found          = 1'b1;
                    req_ready[idx] = 1'b1;
                    grant_idx      = GW'(idx);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (credits == FULL_C && !fifo_wr_en) state_nxt = DONE;
            DONE:    state_nxt = flush_req ? HOLD : RUN;
            HOLD:    if (!flush_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A pop at full credit with no accept is a consumer bug: flag it, keep credits pinned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits       <= FULL_C;
            err_underflow <= 1'b0;
        end else if (accept && !fifo_pop) begin
            credits <= credits - ONE_C;
        end else if (!accept && fifo_pop) begin
            if (credits == FULL_C) begin
                err_underflow <= 1'b1;
            end else begin
                credits <= credits + ONE_C;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            last_grant <= '0;
            fifo_wr_en <= 1'b0;
            fifo_data  <= '0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                rr_ptr     <= (grant_idx == LAST_C) ? '0 : grant_idx + GW'(1);
                last_grant <= grant_idx;
                fifo_data  <= req_data[grant_idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data;
    logic        fifo_pop = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [4:0]  credits;
    logic [1:0]  last_grant;
    logic        err_underflow;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .flush_req(flush_req), .flush_done(flush_done), .credits(credits),
        .last_grant(last_grant), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: free slots, next-priority index, flush phase (0 run,1 drain,2 done,3 hold).
    int         m_cred, m_rr, m_last, m_phase, m_err;
    logic       m_wr;
    logic [7:0] m_data;

    logic [3:0] o_ready, e_ready;
    logic       o_wr, e_wr, o_done, e_done, o_err, e_err;
    logic [7:0] o_data, e_data;
    logic [4:0] o_cred, e_cred;
    logic [1:0] o_last, e_last;

    task automatic model_reset();
        m_cred = 16; m_rr = 0; m_last = 0; m_phase = 0; m_err = 0;
        m_wr = 1'b0; m_data = 8'h00;
    endtask

    function automatic int model_grant(input logic [3:0] v);
        if (m_phase != 0 || m_cred == 0) return -1;
        for (int off = 0; off < 4; off++)
            if (v[(m_rr + off) % 4]) return (m_rr + off) % 4;
        return -1;
    endfunction

    // Apply one cycle of inputs, capture DUT outputs and model expectations, then advance the model.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic p, input logic f);
        int g, nc, np;
        @(negedge clk);
        req_valid = v; req_data = d; fifo_pop = p; flush_req = f;
        #1;
        o_ready = req_ready; o_wr = fifo_wr_en; o_data = fifo_data; o_cred = credits;
        o_last = last_grant; o_done = flush_done; o_err = err_underflow;
        g = model_grant(v);
        e_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        e_wr = m_wr; e_data = m_data; e_cred = 5'(m_cred); e_last = 2'(m_last);
        e_done = (m_phase == 2); e_err = (m_err != 0);
        nc = m_cred;
        if (g >= 0 && !p) nc = m_cred - 1;
        else if (g < 0 && p) begin
            if (m_cred == 16) m_err = 1;
            else nc = m_cred + 1;
        end
        np = m_phase;
        case (m_phase)
            0: if (f) np = 1;
            1: if (m_cred == 16 && !m_wr) np = 2;
            2: np = f ? 3 : 0;
            default: if (!f) np = 0;
        endcase
        if (g >= 0) begin
            m_rr = (g + 1) % 4; m_last = g; m_data = d[g*8 +: 8];
        end
        m_wr = (g >= 0);
        m_cred = nc; m_phase = np;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_data = '0; fifo_pop = 1'b0; flush_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        step(4'b0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (o_cred !== 5'd16) begin n_err++; $display("FAIL reset_credits got %0d want 16", o_cred); end
        n_vec++; if (o_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want 0000", o_ready); end
        n_vec++; if (o_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", o_wr); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done got %b want 0", o_done); end
        n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", o_err); end
        n_vec++; if (o_last !== 2'd0 || o_data !== 8'h00) begin n_err++; $display("FAIL reset_last_data got %0d/%h want 0/00", o_last, o_data); end
    endtask

    task automatic test_rotation();
        logic [31:0] d;
        d = 32'h13121110;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step((i < 8) ? 4'hF : 4'h0, d, 1'b0, 1'b0);
            if (i < 8) begin
                n_vec++;
                if (o_ready !== (4'b0001 << (i % 4))) begin n_err++; $display("FAIL rotation_grant cyc %0d got %b want %b", i, o_ready, 4'b0001 << (i % 4)); end
            end
            if (i > 0) begin
                n_vec++;
                if (o_wr !== 1'b1 || o_data !== 8'(8'h10 + ((i - 1) % 4))) begin
                    n_err++; $display("FAIL rotation_write cyc %0d got wr=%b data=%h want wr=1 data=%h", i, o_wr, o_data, 8'(8'h10 + ((i - 1) % 4)));
                end
            end
        end
        n_vec++; if (o_cred !== 5'd8) begin n_err++; $display("FAIL rotation_credits got %0d want 8", o_cred); end
    endtask

    task automatic test_full_boundary();
        int acc;
        acc = 0;
        apply_reset();
        for (int i = 0; i < 18; i++) begin
            step(4'b0100, $urandom, 1'b0, 1'b0);
            if (o_ready[2]) acc++;
            n_vec++;
            if (o_ready !== e_ready || (i >= 16 && o_ready !== 4'b0)) begin
                n_err++; $display("FAIL full_ready cyc %0d got %b want %b", i, o_ready, e_ready);
            end
            if (i == 17) begin
                n_vec++; if (o_wr !== 1'b0) begin n_err++; $display("FAIL full_no_strobe got %b want 0", o_wr); end
            end
        end
        n_vec++; if (acc != 16) begin n_err++; $display("FAIL full_accepts got %0d want 16", acc); end
        step(4'b0100, 32'h00AA0000, 1'b1, 1'b0);
        n_vec++; if (o_cred !== 5'd0 || o_ready !== 4'b0) begin n_err++; $display("FAIL full_pop_cycle got cred=%0d ready=%b want 0/0000", o_cred, o_ready); end
        step(4'b0100, 32'h00AA0000, 1'b0, 1'b0);
        n_vec++; if (o_cred !== 5'd1 || o_ready !== 4'b0100) begin n_err++; $display("FAIL full_reenable got cred=%0d ready=%b want 1/0100", o_cred, o_ready); end
        step(4'b0100, 32'h00AA0000, 1'b0, 1'b0);
        n_vec++; if (o_cred !== 5'd0 || o_ready !== 4'b0 || o_data !== 8'hAA) begin n_err++; $display("FAIL full_refill got cred=%0d ready=%b data=%h want 0/0000/aa", o_cred, o_ready, o_data); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 11; i++) step(4'($urandom_range(1, 15)), $urandom, 1'b0, 1'b0);
        step(4'($urandom_range(1, 15)), $urandom, 1'b1, 1'b0);
        n_vec++; if (o_cred !== 5'd5 || o_ready === 4'b0) begin n_err++; $display("FAIL simul_setup got cred=%0d ready=%b want 5/nonzero", o_cred, o_ready); end
        step(4'b0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (o_cred !== 5'd5) begin n_err++; $display("FAIL simul_credits got %0d want 5", o_cred); end
    endtask

    task automatic test_flush();
        int c16, dn, pulses, saved;
        c16 = -1; dn = -1; pulses = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) step(4'hF, $urandom, 1'b0, 1'b0);
        step(4'hF, $urandom, 1'b0, 1'b1);
        n_vec++; if (o_cred !== 5'd13 || o_ready !== e_ready || o_ready === 4'b0) begin n_err++; $display("FAIL flush_edge_accept got cred=%0d ready=%b want 13/%b", o_cred, o_ready, e_ready); end
        for (int i = 0; i < 10; i++) begin
            step(4'hF, $urandom, (m_cred < 16), 1'b1);
            if (c16 < 0 && o_cred == 5'd16) c16 = i;
            if (o_done) begin pulses++; dn = i; end
            n_vec++; if (o_ready !== 4'b0) begin n_err++; $display("FAIL flush_no_grant cyc %0d got %b want 0000", i, o_ready); end
        end
        n_vec++; if (pulses != 1 || c16 < 0 || dn != c16 + 1) begin n_err++; $display("FAIL flush_done_timing got pulses=%0d at %0d want 1 at %0d", pulses, dn, c16 + 1); end
        saved = m_rr;
        step(4'hF, $urandom, 1'b0, 1'b0);
        n_vec++; if (o_ready !== 4'b0) begin n_err++; $display("FAIL flush_hold_exit got %b want 0000", o_ready); end
        step(4'hF, $urandom, 1'b0, 1'b0);
        n_vec++; if (o_ready !== (4'b0001 << saved)) begin n_err++; $display("FAIL flush_resume got %b want %b", o_ready, 4'b0001 << saved); end
    endtask

    task automatic test_error_reset();
        apply_reset();
        step(4'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0, 32'h0, 1'b0, 1'b0);
            n_vec++; if (o_err !== 1'b1 || o_cred !== 5'd16) begin n_err++; $display("FAIL err_sticky cyc %0d got err=%b cred=%0d want 1/16", i, o_err, o_cred); end
        end
        step(4'hF, 32'h44332211, 1'b0, 1'b1);
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        n_vec++; if (fifo_wr_en !== 1'b1 || fifo_data !== 8'h11) begin n_err++; $display("FAIL drain_inflight got wr=%b data=%h want 1/11", fifo_wr_en, fifo_data); end
        rst = 1'b1;
        #1;
        n_vec++;
        if (credits !== 5'd16 || req_ready !== 4'b0 || fifo_wr_en !== 1'b0 || fifo_data !== 8'h00 ||
            last_grant !== 2'd0 || flush_done !== 1'b0 || err_underflow !== 1'b0) begin
            n_err++; $display("FAIL async_reset got cred=%0d rdy=%b wr=%b data=%h last=%0d done=%b err=%b",
                              credits, req_ready, fifo_wr_en, fifo_data, last_grant, flush_done, err_underflow);
        end
        @(negedge clk);
        rst = 1'b0; flush_req = 1'b0;
        model_reset();
        step(4'b0010, 32'h0, 1'b0, 1'b0);
        n_vec++; if (o_ready !== 4'b0010 || o_cred !== 5'd16) begin n_err++; $display("FAIL post_reset_run got rdy=%b cred=%0d want 0010/16", o_ready, o_cred); end
    endtask

    task automatic test_random();
        logic f;
        f = 1'b0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) f = ~f;
            step(4'($urandom), $urandom, ($urandom_range(0, 2) == 0), f);
            n_vec++;
            if (o_ready !== e_ready || o_wr !== e_wr || o_data !== e_data || o_cred !== e_cred ||
                o_last !== e_last || o_done !== e_done || o_err !== e_err) begin
                n_err++;
                $display("FAIL random cyc %0d got rdy=%b wr=%b d=%h c=%0d l=%0d dn=%b e=%b want rdy=%b wr=%b d=%h c=%0d l=%0d dn=%b e=%b",
                         i, o_ready, o_wr, o_data, o_cred, o_last, o_done, o_err,
                         e_ready, e_wr, e_data, e_cred, e_last, e_done, e_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_full_boundary();
        test_simultaneous();
        test_flush();
        test_error_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
